vga_mode_sequencer: RTL and testbench
=====================================

Name: vga_mode_sequencer

Overview:
- Controller that decides which display mode the VGA colour state machine renders, driving its 2-bit MASTER_CONTROL.
- Takes two raw push-buttons (next/previous), debounces them and queues the requested mode.
- Commits the new mode only at the start of a vertical sync pulse, so the mode never changes mid-frame.
- Optional auto-cycle mode advances one mode every FRAMES_PER_MODE frames.

Parameters:
- DEBOUNCE_CYCLES, 1000000, clock cycles a button level must stay stable before it is accepted (10 ms at 100 MHz).
- FRAMES_PER_MODE, 120, frames per mode in auto-cycle; legal range 1..255.
- NUM_MODES, 4, number of valid modes; legal range 2..4; modes are 0..NUM_MODES-1.

Ports:
- CLK  input  1  system clock; same clock as the VGA interface.
- RESET  input  1  asynchronous, active-high reset.
- BTN_NEXT  input  1  raw button, active-high, asynchronous to CLK.
- BTN_PREV  input  1  raw button, active-high, asynchronous to CLK.
- AUTO_EN  input  1  level; 1 = auto-cycle enabled. Quasi-static; synchronised internally.
- SYNC_V  input  1  vertical sync from the VGA interface, active-low pulse, CLK domain.
- MASTER_CONTROL  output  2  committed display mode, registered.
- MODE_PENDING  output  1  1 while a requested mode is waiting for the next frame boundary.
- FRAME_COUNT  output  8  auto-cycle frame counter, registered.

Behaviour:
- Reset (asynchronous, immediate):
  - MASTER_CONTROL=0, MODE_PENDING=0, requested mode=0, FRAME_COUNT=0.
  - Debouncers go to IDLE; synchroniser flops clear to 0.
  - SYNC_V history register presets to 1 (inactive), so no false frame tick after reset.
- Input synchronisation: BTN_NEXT, BTN_PREV and AUTO_EN each pass through a 2-flop synchroniser.
- Debouncer, one FSM per button:
  - IDLE: waiting for synchronised input = 1. On 1, clear the counter and go to ARMING.
  - ARMING: if input returns to 0, go to IDLE. Otherwise, when the counter reaches DEBOUNCE_CYCLES-1, emit a one-cycle press pulse and go to HELD.
  - HELD: stays until input = 0, then clear the counter and go to RELEASING.
  - RELEASING: if input returns to 1, go back to HELD. If input stays 0 for DEBOUNCE_CYCLES cycles, go to IDLE.
  - Exactly one press pulse per accepted press; holding a button never auto-repeats.
- Request register:
  - NEXT pulse: req = (req == NUM_MODES-1) ? 0 : req+1.
  - PREV pulse: req = (req == 0) ? NUM_MODES-1 : req-1.
  - NEXT and PREV pulses in the same cycle: both ignored; req unchanged.
  - Any applied pulse sets MODE_PENDING=1 and clears FRAME_COUNT to 0.
  - Several presses before one frame tick accumulate; only the final req is committed.
  - A pulse that returns req to MASTER_CONTROL still leaves MODE_PENDING=1 until the next tick.
- Frame tick: a one-cycle pulse when the registered SYNC_V = 1 and current SYNC_V = 0 (falling edge).
- At a frame tick, in priority order:
  1. MODE_PENDING=1: MASTER_CONTROL<=req, MODE_PENDING<=0, FRAME_COUNT<=0; the auto step is skipped for this tick.
  2. Else if synchronised AUTO_EN=1 and FRAME_COUNT == FRAMES_PER_MODE-1: MASTER_CONTROL and req both advance by one with wrap; FRAME_COUNT<=0.
  3. Else if AUTO_EN=1: FRAME_COUNT increments by 1.
- Button pulse and frame tick in the same cycle: the tick commits the old req; the pulse updates req and sets MODE_PENDING=1, so the new mode commits on the following tick.
- AUTO_EN=0: FRAME_COUNT is held at 0.
- Latency:
  - MASTER_CONTROL changes on the 2nd rising edge after SYNC_V falls: one edge to register the tick, one to commit.
  - A press is recognised DEBOUNCE_CYCLES+2 cycles after the raw input becomes stable.
- Reset asserted mid-operation: pending requests and partially debounced presses are discarded; behaviour resumes as from power-up.

Test Plan (DEBOUNCE_CYCLES=4, FRAMES_PER_MODE=3, NUM_MODES=4):
- Reset, hold BTN_NEXT high for 10 cycles, pulse SYNC_V low -> MODE_PENDING=1 from the press pulse until the tick; MASTER_CONTROL 0->1 exactly 2 edges after SYNC_V falls.
- Bounce BTN_NEXT 1/0 every 2 cycles for 20 cycles, then release -> no press pulse; MODE_PENDING stays 0; MASTER_CONTROL stays 0.
- From mode 0, press PREV once, then frame tick -> MASTER_CONTROL=3 (wrap). From 3, press NEXT, then tick -> 0.
- Press NEXT 3 times between two frame ticks starting from 0 -> no change before the tick; MASTER_CONTROL=3 after it; MODE_PENDING cleared.
- AUTO_EN=1, no presses, 7 frame ticks -> FRAME_COUNT sequence 1,2,0,1,2,0,1; MASTER_CONTROL 0->1 on tick 3 and 1->2 on tick 6.
- Button pulse coincident with a tick while pending req=2 and MASTER_CONTROL=0 -> MASTER_CONTROL=2 at this tick; req=3 and MODE_PENDING=1; MASTER_CONTROL=3 on the next tick. Separately, assert RESET mid-ARMING -> all outputs 0; a SYNC_V already low at reset release produces no tick.

Source files
------------

// File: rtl/vga_mode_sequencer.sv
// vga_mode_sequencer: debounced next/prev buttons and optional auto-cycle
// pick the VGA display mode, committed only at a vertical-sync boundary.

module vga_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic press
);

   localparam int CW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARMING,
      HELD,
      RELEASING
   } db_state_t;

   db_state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic done;

   assign done = (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press     = 1'b0;
      unique case (state)
         IDLE: begin
            if (level) begin
               cnt_nxt   = '0;
               state_nxt = ARMING;
            end
         end
         ARMING: begin
            if (!level) begin
               state_nxt = IDLE;
            end else if (done) begin
               press     = 1'b1;
               state_nxt = HELD;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HELD: begin
            if (!level) begin
               cnt_nxt   = '0;
               state_nxt = RELEASING;
            end
         end
         RELEASING: begin
            if (level) begin
               state_nxt = HELD;
            end else if (done) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
      endcase
   end

endmodule

module vga_mode_sequencer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int FRAMES_PER_MODE = 120,
   parameter int NUM_MODES       = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       BTN_NEXT,
   input  logic       BTN_PREV,
   input  logic       AUTO_EN,
   input  logic       SYNC_V,
   output logic [1:0] MASTER_CONTROL,
   output logic       MODE_PENDING,
   output logic [7:0] FRAME_COUNT
);

   localparam logic [1:0] MODE_LAST  = 2'(NUM_MODES - 1);
   localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_MODE - 1);

   logic [1:0] next_sync, prev_sync, auto_sync;
   logic       next_press, prev_press, auto_s, step;
   logic       sync_v_q, live, tick;
   logic       commit, wrap, count, frame_last;
   logic [1:0] req;

   function automatic logic [1:0] mode_inc(input logic [1:0] m);
      return (m == MODE_LAST) ? 2'd0 : m + 2'd1;
   endfunction

   function automatic logic [1:0] mode_dec(input logic [1:0] m);
      return (m == 2'd0) ? MODE_LAST : m - 2'd1;
   endfunction

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         next_sync <= '0;
         prev_sync <= '0;
         auto_sync <= '0;
      end else begin
         next_sync <= {next_sync[0], BTN_NEXT};
         prev_sync <= {prev_sync[0], BTN_PREV};
         auto_sync <= {auto_sync[0], AUTO_EN};
      end
   end

   assign auto_s = auto_sync[1];

   vga_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_next (
      .clk  (CLK),
      .rst  (RESET),
      .level(next_sync[1]),
      .press(next_press)
   );

   vga_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_prev (
      .clk  (CLK),
      .rst  (RESET),
      .level(prev_sync[1]),
      .press(prev_press)
   );

   // simultaneous next+prev cancel each other
   assign step       = next_press ^ prev_press;
   assign frame_last = (FRAME_COUNT == FRAME_LAST);
   assign commit     = tick && MODE_PENDING;
   assign wrap  = tick && !MODE_PENDING && auto_s && frame_last;
   assign count = tick && !MODE_PENDING && auto_s && !frame_last;

   // live gates the first edge after reset so a low SYNC_V is no tick
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync_v_q       <= 1'b1;
         live           <= 1'b0;
         tick           <= 1'b0;
         req            <= 2'd0;
         MASTER_CONTROL <= 2'd0;
         MODE_PENDING   <= 1'b0;
         FRAME_COUNT    <= 8'd0;
      end else begin
         sync_v_q <= SYNC_V;
         live     <= 1'b1;
         tick     <= live & sync_v_q & ~SYNC_V;
         unique case (1'b1)
            commit: begin
               MASTER_CONTROL <= req;
               MODE_PENDING   <= 1'b0;
               FRAME_COUNT    <= 8'd0;
            end
            wrap: begin
               MASTER_CONTROL <= mode_inc(MASTER_CONTROL);
               req            <= mode_inc(req);
               FRAME_COUNT    <= 8'd0;
            end
            count: FRAME_COUNT <= FRAME_COUNT + 8'd1;
            default: ;
         endcase
         if (step) begin
            req          <= next_press ? mode_inc(req)
                                       : mode_dec(req);
            MODE_PENDING <= 1'b1;
            FRAME_COUNT  <= 8'd0;
         end
         if (!auto_s) FRAME_COUNT <= 8'd0;
      end
   end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// tb_vga_mode_sequencer: directed and random stimulus checked every cycle
// against a run-length / modular-arithmetic reference model.

module tb_vga_mode_sequencer;

   localparam int DEB = 4;
   localparam int FPM = 3;
   localparam int NM  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_next, btn_prev, auto_en, sync_v;
   logic [1:0] mc;
   logic       pend;
   logic [7:0] fc;

   int checks = 0;
   int errors = 0;

   int exp_fc[7] = '{1, 2, 0, 1, 2, 0, 1};
   int exp_mc[7] = '{0, 0, 1, 1, 1, 2, 2};

   // reference model state
   int m_mc, m_req, m_fc;
   bit m_pend, m_tick, m_live, m_sv;
   bit sy_n[2], sy_p[2], sy_a[2];
   bit lvl[2], down[2];
   int run[2];

   vga_mode_sequencer #(
      .DEBOUNCE_CYCLES(DEB),
      .FRAMES_PER_MODE(FPM),
      .NUM_MODES      (NM)
   ) dut (
      .CLK           (clk),
      .RESET         (rst),
      .BTN_NEXT      (btn_next),
      .BTN_PREV      (btn_prev),
      .AUTO_EN       (auto_en),
      .SYNC_V        (sync_v),
      .MASTER_CONTROL(mc),
      .MODE_PENDING  (pend),
      .FRAME_COUNT   (fc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // A press is a run of D+1 synchronised highs while released;
   // a release is a run of D+1 synchronised lows while pressed.
   task automatic model_step();
      bit s[2];
      bit pr[2];
      bit a;
      int o_req;
      if (rst) begin
         m_mc = 0; m_req = 0; m_fc = 0; m_pend = 0;
         m_tick = 0; m_live = 0; m_sv = 1;
         for (int b = 0; b < 2; b++) begin
            sy_n[b] = 0; sy_p[b] = 0; sy_a[b] = 0;
            lvl[b] = 0; down[b] = 0; run[b] = 0;
         end
         return;
      end
      s[0] = sy_n[1];
      s[1] = sy_p[1];
      a    = sy_a[1];
      for (int b = 0; b < 2; b++) begin
         pr[b] = 0;
         if (s[b] == lvl[b]) run[b]++;
         else begin
            lvl[b] = s[b];
            run[b] = 1;
         end
         if (run[b] == DEB + 1) begin
            if (s[b] && !down[b]) begin
               pr[b]   = 1;
               down[b] = 1;
            end else if (!s[b] && down[b]) begin
               down[b] = 0;
            end
         end
      end
      o_req = m_req;
      if (m_tick) begin
         if (m_pend) begin
            m_mc = o_req; m_pend = 0; m_fc = 0;
         end else if (a && m_fc == FPM - 1) begin
            m_mc  = (m_mc + 1) % NM;
            m_req = (o_req + 1) % NM;
            m_fc  = 0;
         end else if (a) begin
            m_fc++;
         end
      end
      if (pr[0] != pr[1]) begin
         m_req  = pr[0] ? (o_req + 1) % NM : (o_req + NM - 1) % NM;
         m_pend = 1;
         m_fc   = 0;
      end
      if (!a) m_fc = 0;
      m_tick = m_live && m_sv && !sync_v;
      m_sv   = sync_v;
      m_live = 1;
      sy_n[1] = sy_n[0]; sy_n[0] = btn_next;
      sy_p[1] = sy_p[0]; sy_p[0] = btn_prev;
      sy_a[1] = sy_a[0]; sy_a[0] = auto_en;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         check("mc", {6'd0, mc}, 8'(m_mc));
         check("pending", {7'd0, pend}, 8'(m_pend));
         check("frame_count", fc, 8'(m_fc));
      end
   endtask

   task automatic press(input bit nxt, input int hold);
      if (nxt) btn_next = 1'b1;
      else     btn_prev = 1'b1;
      cycles(hold);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      cycles(10);
   endtask

   task automatic vsync();
      sync_v = 1'b0;
      cycles(2);
      sync_v = 1'b1;
      cycles(2);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      cycles(2);
   endtask

   initial begin
      rst = 1'b1;
      btn_next = 1'b0;
      btn_prev = 1'b0;
      auto_en = 1'b0;
      sync_v = 1'b1;
      cycles(2);
      check("rst_mc", {6'd0, mc}, 8'd0);
      check("rst_pend", {7'd0, pend}, 8'd0);
      check("rst_fc", fc, 8'd0);
      rst = 1'b0;
      cycles(2);

      // held press, then two-edge commit latency
      press(1'b1, 10);
      check("t1_pend", {7'd0, pend}, 8'd1);
      sync_v = 1'b0;
      cycles(1);
      check("t1_mc_edge1", {6'd0, mc}, 8'd0);
      cycles(1);
      check("t1_mc_edge2", {6'd0, mc}, 8'd1);
      check("t1_pend_clr", {7'd0, pend}, 8'd0);
      sync_v = 1'b1;
      cycles(2);

      // bouncing button is rejected
      do_reset();
      for (int i = 0; i < 10; i++) begin
         btn_next = ~btn_next;
         cycles(2);
      end
      btn_next = 1'b0;
      cycles(10);
      check("t2_pend", {7'd0, pend}, 8'd0);
      vsync();
      check("t2_mc", {6'd0, mc}, 8'd0);

      // wrap in both directions
      press(1'b0, 8);
      vsync();
      check("t3_prev_wrap", {6'd0, mc}, 8'd3);
      press(1'b1, 8);
      vsync();
      check("t3_next_wrap", {6'd0, mc}, 8'd0);

      // accumulated presses commit only the final request
      for (int i = 0; i < 3; i++) press(1'b1, 8);
      check("t4_mc_before", {6'd0, mc}, 8'd0);
      check("t4_pend", {7'd0, pend}, 8'd1);
      vsync();
      check("t4_mc_after", {6'd0, mc}, 8'd3);
      check("t4_pend_clr", {7'd0, pend}, 8'd0);

      // auto-cycle
      do_reset();
      auto_en = 1'b1;
      cycles(4);
      for (int k = 0; k < 7; k++) begin
         vsync();
         check("t5_fc", fc, 8'(exp_fc[k]));
         check("t5_mc", {6'd0, mc}, 8'(exp_mc[k]));
      end
      auto_en = 1'b0;
      cycles(4);

      // press pulse coincident with the commit edge
      do_reset();
      press(1'b1, 8);
      press(1'b1, 8);
      btn_next = 1'b1;
      cycles(5);
      sync_v = 1'b0;
      cycles(2);
      check("t6_mc_commit", {6'd0, mc}, 8'd2);
      check("t6_pend", {7'd0, pend}, 8'd1);
      sync_v = 1'b1;
      btn_next = 1'b0;
      cycles(12);
      vsync();
      check("t6_mc_next", {6'd0, mc}, 8'd3);
      check("t6_pend_clr", {7'd0, pend}, 8'd0);

      // reset mid-arming, SYNC_V already low at release
      btn_next = 1'b1;
      cycles(4);
      rst = 1'b1;
      btn_next = 1'b0;
      sync_v = 1'b0;
      cycles(1);
      check("t7_rst_mc", {6'd0, mc}, 8'd0);
      check("t7_rst_pend", {7'd0, pend}, 8'd0);
      check("t7_rst_fc", fc, 8'd0);
      rst = 1'b0;
      cycles(4);
      check("t7_mc", {6'd0, mc}, 8'd0);
      check("t7_pend", {7'd0, pend}, 8'd0);
      sync_v = 1'b1;
      cycles(2);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) btn_next = ~btn_next;
         if ($urandom_range(0, 7) == 0) btn_prev = ~btn_prev;
         if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
         if (sync_v && $urandom_range(0, 15) == 0) sync_v = 1'b0;
         else if (!sync_v && $urandom_range(0, 2) == 0) sync_v = 1'b1;
         rst = ($urandom_range(0, 599) == 0);
         cycles(1);
      end
      rst = 1'b0;
      cycles(2);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
